// File: rtl/instruction_fetch_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the fetch front end and the decode stage.
// - Default datapath widths and the bubble word.
// - Fetch FSM state encoding.
// - Opcode encodings, so decode and fetch agree on instruction fields.
// ----------------------------------------------------------------------------
package instruction_fetch_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  // Opcodes live in the top nibble of the instruction word
  localparam logic [3:0] SVPC = 4'b1111;
  localparam logic [3:0] BRN  = 4'b1011;

  // Extracts the opcode nibble from a fetched word
  function automatic logic [3:0] opcode_of(input logic [DATA_W-1:0] word);
    return word[DATA_W-1 -: 4];
  endfunction

endpackage

// File: rtl/instruction_fetch_ifid_reg.sv
// ----------------------------------------------------------------------------
// ifid_reg
// IF/ID pipeline register: instruction word, its PC and a valid bit.
// Ports:
//   clock, reset_n       - clock and synchronous active-low reset
//   load                 - capture instr_in/pc_in as a valid instruction
//   flush                - insert a bubble (NOP, valid=0), pc follows pc_in
//   instr_in, pc_in      - word and PC presented by the fetch stage
//   instr, pc, valid     - registered outputs to decode
// Priority: reset, then flush, then load, otherwise hold.
// ----------------------------------------------------------------------------
module ifid_reg #(
  parameter int                ADDR_W   = instruction_fetch_pkg::ADDR_W,
  parameter int                DATA_W   = instruction_fetch_pkg::DATA_W,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(instruction_fetch_pkg::NOP_WORD)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc,
  output logic              valid
);

  import instruction_fetch_pkg::*;

  // A flush still records the PC of the discarded slot so the bubble can be
  // traced back to the redirecting fetch; holding is the default when neither
  // load nor flush is asserted.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      instr <= NOP_WORD;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_WORD;
      pc    <= pc_in;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_in;
      pc    <= pc_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Pipeline front end: owns the PC, addresses instruction memory, fills the
// IF/ID register and counts captured instructions.
// Ports:
//   clock, reset_n       - clock and synchronous active-low reset
//   stall                - decode hazard: hold PC, IF/ID and counter
//   redirect             - taken branch/jump: PC <= redirect_target, flush IF/ID
//   redirect_target      - new PC on redirect
//   imem_addr            - instruction memory address (the PC, combinational)
//   imem_data            - instruction word returned for imem_addr
//   ifid_instr/pc/valid  - IF/ID pipeline register to decode
//   fetch_count          - valid instructions captured since reset (wraps)
// ----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int                ADDR_W   = instruction_fetch_pkg::ADDR_W,
  parameter int                DATA_W   = instruction_fetch_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(instruction_fetch_pkg::NOP_WORD),
  parameter int                CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic              ifid_valid,
  output logic [CNT_W-1:0]  fetch_count
);

  import instruction_fetch_pkg::*;

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  count;
  logic              capture;

  // A capture happens whenever no redirect is pending and decode is not
  // stalling; BOOT always captures because IF/ID holds nothing worth keeping.
  always_comb begin
    capture = 1'b0;
    if (!redirect) begin
      capture = (state == BOOT) || !stall;
    end
  end

  // Fetch FSM, PC and instruction counter. Redirect beats stall, and the PC
  // and counter both advance modulo their width with no overflow flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= BOOT;
      pc    <= RESET_PC;
      count <= '0;
    end else begin
      state <= RUN;
      if (redirect) begin
        pc <= redirect_target;
      end else if (capture) begin
        pc    <= pc + ADDR_W'(1);
        count <= count + CNT_W'(1);
      end
    end
  end

  ifid_reg #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NOP_WORD (NOP_WORD)
  ) u_ifid_reg (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (capture),
    .flush    (redirect),
    .instr_in (imem_data),
    .pc_in    (pc),
    .instr    (ifid_instr),
    .pc       (ifid_pc),
    .valid    (ifid_valid)
  );

  assign imem_addr   = pc;
  assign fetch_count = count;

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch with a small reference model feeding
// a scoreboard, plus fixed expectations at the interesting points.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

  import instruction_fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_target = '0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ifid_instr;
  logic [7:0]  ifid_pc;
  logic        ifid_valid;
  logic [15:0] fetch_count;

  logic [31:0] mem [256];

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  ipc;
    logic        valid;
    logic [15:0] cnt;
    logic [7:0]  addr;
  } exp_t;

  exp_t sb[$];

  logic [7:0]  m_pc = '0;
  logic [31:0] m_instr = '0;
  logic [7:0]  m_ipc = '0;
  logic        m_valid = 1'b0;
  logic [15:0] m_cnt = '0;
  logic        m_boot = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  // 10 ns clock
  always #5 clock = ~clock;

  // Combinational instruction memory
  assign imem_data = mem[imem_addr];

  instruction_fetch #(
    .ADDR_W   (8),
    .DATA_W   (32),
    .RESET_PC (8'd0),
    .NOP_WORD (32'h0000_0000),
    .CNT_W    (16)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .ifid_instr      (ifid_instr),
    .ifid_pc         (ifid_pc),
    .ifid_valid      (ifid_valid),
    .fetch_count     (fetch_count)
  );

  // One comparison point: counts it and reports a miscompare
  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs at the falling edge and pushes the state the
  // DUT should hold after the next rising edge
  task automatic applyStimulus(input logic rn, input logic st, input logic rd, input logic [7:0] tgt);
    exp_t e;
    @(negedge clock);
    reset_n         = rn;
    stall           = st;
    redirect        = rd;
    redirect_target = tgt;
    if (!rn) begin
      m_pc = 8'd0; m_instr = 32'h0; m_ipc = 8'd0; m_valid = 1'b0; m_cnt = 16'd0; m_boot = 1'b1;
    end else if (rd) begin
      m_ipc = m_pc; m_instr = 32'h0; m_valid = 1'b0; m_pc = tgt; m_boot = 1'b0;
    end else if (m_boot || !st) begin
      m_instr = mem[m_pc]; m_ipc = m_pc; m_valid = 1'b1;
      m_pc = m_pc + 8'd1; m_cnt = m_cnt + 16'd1; m_boot = 1'b0;
    end
    e.instr = m_instr; e.ipc = m_ipc; e.valid = m_valid; e.cnt = m_cnt; e.addr = m_pc;
    sb.push_back(e);
  endtask

  // Samples just after the rising edge and checks against the scoreboard
  task automatic checkOutput();
    exp_t e;
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL sb_empty: observed 0 entries required 1");
    end else begin
      e = sb.pop_front();
      compare("sb_instr", ifid_instr, e.instr);
      compare("sb_ifid_pc", {24'h0, ifid_pc}, {24'h0, e.ipc});
      compare("sb_valid", {31'h0, ifid_valid}, {31'h0, e.valid});
      compare("sb_count", {16'h0, fetch_count}, {16'h0, e.cnt});
      compare("sb_addr", {24'h0, imem_addr}, {24'h0, e.addr});
    end
  endtask

  task automatic step(input logic rn, input logic st, input logic rd, input logic [7:0] tgt);
    applyStimulus(rn, st, rd, tgt);
    checkOutput();
  endtask

  // Free-runs until the fetch address reaches target, with a cycle budget
  task automatic runUntil(input logic [7:0] target);
    for (int i = 0; i < 300 && m_pc != target; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'd0);
    end
    compare("run_until_addr", {24'h0, imem_addr}, {24'h0, target});
  endtask

  initial begin
    logic [7:0] wrap_seq [4];
    wrap_seq[0] = 8'd254; wrap_seq[1] = 8'd255; wrap_seq[2] = 8'd0; wrap_seq[3] = 8'd1;

    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[0] = 32'h0;
    mem[1] = 32'h0;
    mem[2] = 32'h7104_1000;

    // Reset, including one cycle where redirect and stall are also high
    step(1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 1'b1, 8'd99);
    compare("rst_valid", {31'h0, ifid_valid}, 32'd0);
    compare("rst_ifid_pc", {24'h0, ifid_pc}, 32'd0);
    compare("rst_count", {16'h0, fetch_count}, 32'd0);
    compare("rst_addr", {24'h0, imem_addr}, 32'd0);
    compare("rst_state_boot", {31'h0, dut.state == BOOT}, 32'd1);

    // Boot and free run over the first three words
    step(1'b1, 1'b0, 1'b0, 8'd0);
    compare("boot_ifid_pc", {24'h0, ifid_pc}, 32'd0);
    compare("boot_valid", {31'h0, ifid_valid}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 8'd0);
    compare("run_ifid_pc1", {24'h0, ifid_pc}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 8'd0);
    compare("run_ifid_pc2", {24'h0, ifid_pc}, 32'd2);
    compare("run_instr2", ifid_instr, 32'h7104_1000);
    compare("run_count3", {16'h0, fetch_count}, 32'd3);

    // Stall for three cycles at pc=12
    runUntil(8'd12);
    compare("pre_stall_ifid_pc", {24'h0, ifid_pc}, 32'd11);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'd0);
      compare("stall_ifid_pc", {24'h0, ifid_pc}, 32'd11);
      compare("stall_addr", {24'h0, imem_addr}, 32'd12);
      compare("stall_count", {16'h0, fetch_count}, 32'd12);
    end
    step(1'b1, 1'b0, 1'b0, 8'd0);
    compare("unstall_ifid_pc", {24'h0, ifid_pc}, 32'd12);

    // Redirect to 22 from pc=34
    runUntil(8'd34);
    step(1'b1, 1'b0, 1'b1, 8'd22);
    compare("redir_valid", {31'h0, ifid_valid}, 32'd0);
    compare("redir_instr", ifid_instr, 32'h0);
    compare("redir_addr", {24'h0, imem_addr}, 32'd22);
    compare("redir_ifid_pc", {24'h0, ifid_pc}, 32'd34);
    step(1'b1, 1'b0, 1'b0, 8'd0);
    compare("redir_tgt_ifid_pc", {24'h0, ifid_pc}, 32'd22);
    compare("redir_tgt_valid", {31'h0, ifid_valid}, 32'd1);

    // Redirect together with stall: flush wins
    step(1'b1, 1'b1, 1'b1, 8'd5);
    compare("rs_valid", {31'h0, ifid_valid}, 32'd0);
    compare("rs_addr", {24'h0, imem_addr}, 32'd5);
    step(1'b1, 1'b1, 1'b0, 8'd0);
    compare("rs_hold_valid", {31'h0, ifid_valid}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 8'd0);
    compare("rs_tgt_ifid_pc", {24'h0, ifid_pc}, 32'd5);
    compare("rs_tgt_valid", {31'h0, ifid_valid}, 32'd1);

    // PC wrap from 254
    step(1'b1, 1'b0, 1'b1, 8'd254);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'd0);
      compare("wrap_ifid_pc", {24'h0, ifid_pc}, {24'h0, wrap_seq[i]});
    end

    // Reset pulse during a stall at pc=40
    runUntil(8'd40);
    step(1'b1, 1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b1, 1'b0, 8'd0);
    compare("rst2_valid", {31'h0, ifid_valid}, 32'd0);
    compare("rst2_instr", ifid_instr, 32'h0);
    compare("rst2_ifid_pc", {24'h0, ifid_pc}, 32'd0);
    compare("rst2_count", {16'h0, fetch_count}, 32'd0);
    compare("rst2_addr", {24'h0, imem_addr}, 32'd0);
    compare("rst2_state_boot", {31'h0, dut.state == BOOT}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 8'd0);
    compare("rst2_boot_ifid_pc", {24'h0, ifid_pc}, 32'd0);
    compare("rst2_boot_valid", {31'h0, ifid_valid}, 32'd1);
    compare("rst2_boot_count", {16'h0, fetch_count}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
